// File: rtl/matmul_nxn_engine.sv
// NxN unsigned matrix multiply engine: byte-stream operand load, one
// sequential MAC, C = A*B on a flattened output bus with a done flag.
// Ports: clk, rst (sync, active-high), en (run enable), we/data_write
// (operand load), load_full_o, is_done_o, c_flat_o (C(i,j) at
// [(i*N+j)*DW +: DW]).
// Build option: MATMUL_SAT_EN clamps each result to 2^DW-1 instead of
// truncating it to DW bits.
module matmul_nxn_engine #(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW+$clog2(N)+1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            we,
  input  logic [DW-1:0]   data_write,
  output logic            load_full_o,
  output logic            is_done_o,
  output logic [N*N*DW-1:0] c_flat_o
);

  localparam int NN    = N*N;
  localparam int WORDS = 2*NN;
  localparam int WPW   = $clog2(WORDS+1);
  localparam int AW    = $clog2(WORDS);
  localparam int KW    = $clog2(N);

  typedef enum logic [1:0] {
    IDLE, COMPUTE, WRITE, DONE
  } state_t;

  state_t state;

  logic [WPW-1:0]   wp;
  logic [KW-1:0]    i, j, k;
  logic [ACC_W-1:0] acc;
  logic [DW-1:0]    mem [WORDS];

  logic [AW-1:0]    a_addr;
  logic [AW-1:0]    b_addr;
  logic [2*DW-1:0]  prod;
  logic             ld_ok;
  int               c_idx;

  assign load_full_o = (wp == WPW'(WORDS));

  // Loads are only accepted while no computation is reading the store.
  assign ld_ok = we && !load_full_o &&
                 (state == IDLE || state == DONE);

  assign a_addr = AW'(int'(i)*N + int'(k));
  assign b_addr = AW'(NN + int'(k)*N + int'(j));
  assign prod   = (2*DW)'(mem[a_addr]) * (2*DW)'(mem[b_addr]);
  assign c_idx  = int'(i)*N + int'(j);

  function automatic logic [DW-1:0] reduce(
    input logic [ACC_W-1:0] a
  );
`ifdef MATMUL_SAT_EN
    if (a > ACC_W'({DW{1'b1}}))
      return {DW{1'b1}};
    return a[DW-1:0];
`else
    return a[DW-1:0];
`endif
  endfunction

  // Operand store has no reset; contents survive runs and resets.
  always_ff @(posedge clk) begin
    if (!rst && ld_ok)
      mem[wp[AW-1:0]] <= data_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wp        <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      is_done_o <= 1'b0;
      c_flat_o  <= '0;
    end else begin
      if (ld_ok)
        wp <= wp + WPW'(1);
      unique case (state)
        IDLE: begin
          is_done_o <= 1'b0;
          if (en && load_full_o) begin
            state <= COMPUTE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            wp    <= '0;
          end
        end
        COMPUTE: begin
          if (!en) begin
            state <= IDLE;
            acc   <= '0;
            k     <= '0;
          end else begin
            acc <= acc + ACC_W'(prod);
            if (k == KW'(N-1)) begin
              k     <= '0;
              state <= WRITE;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        WRITE: begin
          acc <= '0;
          if (!en) begin
            state <= IDLE;
          end else begin
            c_flat_o[c_idx*DW +: DW] <= reduce(acc);
            if (j == KW'(N-1)) begin
              j <= '0;
              if (i == KW'(N-1)) begin
                i     <= '0;
                state <= DONE;
              end else begin
                i     <= i + KW'(1);
                state <= COMPUTE;
              end
            end else begin
              j     <= j + KW'(1);
              state <= COMPUTE;
            end
          end
        end
        DONE: begin
          if (!en) begin
            state     <= IDLE;
            is_done_o <= 1'b0;
          end else begin
            is_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_nxn_engine.sv
// Directed bench for matmul_nxn_engine: N=2 and N=3 instances,
// hand-computed results, latency, load limits, abort and reset.
module tb_matmul_nxn_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, we = 1'b0;
  logic [7:0]  dw = '0;
  logic        full, done;
  logic [31:0] cf;
  logic        en3 = 1'b0, we3 = 1'b0;
  logic [7:0]  dw3 = '0;
  logic        full3, done3;
  logic [71:0] cf3;

  int total = 0;
  int bad = 0;
  int cnt;
  logic saw;
  logic [7:0] e200;

  always #5 clk = ~clk;

  matmul_nxn_engine #(.N(2), .DW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we),
    .data_write(dw), .load_full_o(full),
    .is_done_o(done), .c_flat_o(cf)
  );

  matmul_nxn_engine #(.N(3), .DW(8)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .we(we3),
    .data_write(dw3), .load_full_o(full3),
    .is_done_o(done3), .c_flat_o(cf3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [71:0] obs,
                     input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] v);
    we = 1'b1;
    dw = v;
    step();
    we = 1'b0;
  endtask

  task automatic wr3(input logic [7:0] v);
    we3 = 1'b1;
    dw3 = v;
    step();
    we3 = 1'b0;
  endtask

  // Raise en (edge E0) and count edges until is_done_o is seen.
  task automatic run(output int n);
    en = 1'b1;
    step();
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (done) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    e200 = 8'd128;
`ifdef MATMUL_SAT_EN
    e200 = 8'd255;
`endif
    step();
    step();
    chk("rst_cflat", 72'(cf), 72'h0);
    chk("rst_full", 72'(full), 72'h0);
    chk("rst_done", 72'(done), 72'h0);
    rst = 1'b0;
    step();

    // Basic 2x2 product and latency
    for (int v = 1; v <= 8; v++) wr(8'(v));
    chk("full_after8", 72'(full), 72'h1);
    run(cnt);
    chk("lat_n2", 72'(cnt), 72'd13);
    chk("c_basic", 72'(cf), 72'h322B1613);
    chk("full_drop", 72'(full), 72'h0);
    en = 1'b0;
    step();
    chk("done_clr", 72'(done), 72'h0);

    // Wide accumulator, reduced result
    for (int v = 0; v < 8; v++) wr(8'd200);
    run(cnt);
    chk("c_200", 72'(cf), 72'({4{e200}}));
    en = 1'b0;
    step();

    // Ten words: the two extras must be dropped
    for (int v = 1; v <= 8; v++) wr(8'(v));
    wr(8'd99);
    wr(8'd99);
    chk("full_over", 72'(full), 72'h1);
    run(cnt);
    chk("c_over", 72'(cf), 72'h322B1613);
    en = 1'b0;
    step();

    // Partial load: en must not start a run
    wr(8'd2); wr(8'd0); wr(8'd0); wr(8'd2); wr(8'd1);
    chk("full_part", 72'(full), 72'h0);
    en = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      step();
      if (done) saw = 1'b1;
    end
    chk("part_nodone", 72'(saw), 72'h0);
    chk("part_cflat", 72'(cf), 72'h322B1613);
    en = 1'b0;
    step();

    // Finish load, then abort after C(0,0) is written
    wr(8'd2); wr(8'd3); wr(8'd4);
    chk("full_resume", 72'(full), 72'h1);
    en = 1'b1;
    step();
    repeat (4) begin
      step();
      if (done) saw = 1'b1;
    end
    en = 1'b0;
    repeat (5) begin
      step();
      if (done) saw = 1'b1;
    end
    chk("abort_cflat", 72'(cf), 72'h322B1602);
    chk("abort_nodone", 72'(saw), 72'h0);

    // Last word and en in the same cycle
    for (int v = 1; v <= 7; v++) wr(8'(v));
    we = 1'b1;
    dw = 8'd8;
    en = 1'b1;
    step();
    we = 1'b0;
    chk("same_full", 72'(full), 72'h1);
    chk("same_done", 72'(done), 72'h0);
    run(cnt);
    chk("same_lat", 72'(cnt), 72'd13);
    chk("same_c", 72'(cf), 72'h322B1613);
    en = 1'b0;
    step();

    // Reset mid-compute, then reload and rerun
    wr(8'd2); wr(8'd0); wr(8'd0); wr(8'd2);
    wr(8'd1); wr(8'd2); wr(8'd3); wr(8'd4);
    en = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_c", 72'(cf), 72'h0);
    chk("mid_rst_full", 72'(full), 72'h0);
    chk("mid_rst_done", 72'(done), 72'h0);
    rst = 1'b0;
    en = 1'b0;
    step();
    wr(8'd2); wr(8'd0); wr(8'd0); wr(8'd2);
    wr(8'd1); wr(8'd2); wr(8'd3); wr(8'd4);
    run(cnt);
    chk("rerun_c", 72'(cf), 72'h08060402);
    en = 1'b0;
    step();

    // N=3: identity times 1..9
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        wr3((r == c) ? 8'd1 : 8'd0);
    for (int v = 1; v <= 9; v++) wr3(8'(v));
    chk("n3_full", 72'(full3), 72'h1);
    en3 = 1'b1;
    step();
    cnt = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (done3) begin
        cnt = c;
        break;
      end
    end
    chk("n3_lat", 72'(cnt), 72'd37);
    chk("n3_c", cf3, 72'h090807060504030201);
    en3 = 1'b0;
    step();
    chk("n3_done_clr", 72'(done3), 72'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
